// File: rtl/prog_wave_gen_pkg.sv
// Shared types and mode encodings for the programmable waveform generator.
package prog_wave_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_TOGGLE  = 2'b00;
  localparam logic [1:0] MODE_PWM     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_BURST   = 2'b11;

endpackage

// File: rtl/wave_down_cnt.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module wave_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/prog_wave_gen.sv
// Programmable waveform generator: toggle, PWM, one-shot and counted burst on a
// single registered output, with start/stop/enable control and busy/done status.
module prog_wave_gen
  import prog_wave_gen_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   high_len,
  input  logic [CNT_W-1:0]   low_len,
  input  logic [BURST_W-1:0] burst_n,
  output logic               y,
  output logic               busy,
  output logic               done
);

  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len,
                                               input logic force_one);
    return (force_one || (len == '0)) ? CNT_W'(1) : len;
  endfunction

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_hl;
  logic [CNT_W-1:0] r_ll;
  logic             r_done;

  state_t           w_state_nxt;
  logic             w_done_nxt;
  logic             w_start_acc;
  logic             w_shadow_ld;
  logic             w_ph_load;
  logic             w_ph_dec;
  logic [CNT_W-1:0] w_ph_val;
  logic             w_ph_zero;
  logic             w_bc_load;
  logic             w_bc_dec;
  logic             w_bc_zero;
  logic             w_force_one;
  logic [CNT_W-1:0] w_new_hl;
  logic [CNT_W-1:0] w_new_ll;

  // Lengths come from the live inputs both at start and at a toggle/PWM period boundary.
  assign w_force_one = (((r_state == IDLE) ? mode : r_mode) == MODE_TOGGLE);
  assign w_new_hl    = eff_len(high_len, w_force_one);
  assign w_new_ll    = eff_len(low_len, w_force_one);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_start_acc = 1'b0;
    w_shadow_ld = 1'b0;
    w_ph_load   = 1'b0;
    w_ph_dec    = 1'b0;
    w_ph_val    = '0;
    w_bc_load   = 1'b0;
    w_bc_dec    = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
    end else if (en) begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_start_acc = 1'b1;
            w_shadow_ld = 1'b1;
            if ((mode == MODE_BURST) && (burst_n == '0)) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = HIGH;
              w_ph_load   = 1'b1;
              w_ph_val    = w_new_hl - CNT_W'(1);
              // Burst counter holds pulses remaining after the current one.
              w_bc_load   = 1'b1;
            end
          end
        end
        HIGH: begin
          if (!w_ph_zero) begin
            w_ph_dec = 1'b1;
          end else if (r_mode == MODE_ONESHOT) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = LOW;
            w_ph_load   = 1'b1;
            w_ph_val    = r_ll - CNT_W'(1);
          end
        end
        LOW: begin
          if (!w_ph_zero) begin
            w_ph_dec = 1'b1;
          end else if (r_mode == MODE_BURST) begin
            if (w_bc_zero) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = HIGH;
              w_bc_dec    = 1'b1;
              w_ph_load   = 1'b1;
              w_ph_val    = r_hl - CNT_W'(1);
            end
          end else if (r_mode == MODE_ONESHOT) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HIGH;
            w_shadow_ld = 1'b1;
            w_ph_load   = 1'b1;
            w_ph_val    = w_new_hl - CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mode  <= MODE_TOGGLE;
      r_hl    <= '0;
      r_ll    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_start_acc) r_mode <= mode;
      if (w_shadow_ld) begin
        r_hl <= w_new_hl;
        r_ll <= w_new_ll;
      end
    end
  end

  wave_down_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_val),
    .i_dec      (w_ph_dec),
    .o_zero     (w_ph_zero)
  );

  wave_down_cnt #(.W(BURST_W)) u_burst_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_bc_load),
    .i_load_val (burst_n - BURST_W'(1)),
    .i_dec      (w_bc_dec),
    .o_zero     (w_bc_zero)
  );

  assign y    = (r_state == HIGH);
  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_prog_wave_gen.sv
// Scoreboard bench: expected {y,busy,done} per cycle is queued with the stimulus
// and compared one entry per clock after the edge.
module tb_prog_wave_gen;
  import prog_wave_gen_pkg::*;

  localparam logic [2:0] V_HI   = 3'b110;
  localparam logic [2:0] V_LO   = 3'b010;
  localparam logic [2:0] V_DONE = 3'b001;
  localparam logic [2:0] V_IDLE = 3'b000;

  logic       clk = 1'b0;
  logic       rst, en, start, stop;
  logic [1:0] mode;
  logic [7:0] high_len, low_len;
  logic [3:0] burst_n;
  logic       y, busy, done;

  typedef struct {
    string      tag;
    logic [2:0] v;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  prog_wave_gen dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .high_len (high_len),
    .low_len  (low_len),
    .burst_n  (burst_n),
    .y        (y),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: {y,busy,done} got=%b want=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_n(input string tag, input int n, input logic [2:0] v);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.v   = v;
      q.push_back(e);
    end
  endtask

  task automatic run_q();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      check(e.tag, {y, busy, done}, e.v);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
    mode = MODE_TOGGLE; high_len = 8'd0; low_len = 8'd0; burst_n = 4'd0;
    #3 check("reset", {y, busy, done}, V_IDLE);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Toggle ignores programmed lengths
    mode = MODE_TOGGLE; high_len = 8'd5; low_len = 8'd7; start = 1'b1;
    expect_n("tog", 1, V_HI); run_q(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_n("tog", 1, V_LO); expect_n("tog", 1, V_HI);
    end
    run_q();
    stop = 1'b1; expect_n("tog_stop", 1, V_IDLE); run_q(); stop = 1'b0;

    // PWM 3/2, then shorten high phase mid-HIGH
    mode = MODE_PWM; high_len = 8'd3; low_len = 8'd2; start = 1'b1;
    expect_n("pwm", 1, V_HI); run_q(); start = 1'b0;
    expect_n("pwm", 2, V_HI); expect_n("pwm", 2, V_LO);
    expect_n("pwm", 3, V_HI); expect_n("pwm", 2, V_LO);
    expect_n("pwm", 1, V_HI); run_q();
    high_len = 8'd1;
    expect_n("pwm_upd", 2, V_HI); expect_n("pwm_upd", 2, V_LO);
    expect_n("pwm_new", 1, V_HI); expect_n("pwm_new", 2, V_LO);
    expect_n("pwm_new", 1, V_HI); run_q();
    stop = 1'b1; expect_n("pwm_stop", 1, V_IDLE); run_q(); stop = 1'b0;
    expect_n("pwm_nodone", 2, V_IDLE); run_q();

    // One-shot with an ignored second start
    mode = MODE_ONESHOT; high_len = 8'd4; start = 1'b1;
    expect_n("one", 1, V_HI); run_q(); start = 1'b0;
    expect_n("one", 1, V_HI); run_q(); start = 1'b1;
    expect_n("one_restart", 1, V_HI); run_q(); start = 1'b0;
    expect_n("one", 1, V_HI); expect_n("one_done", 1, V_DONE);
    expect_n("one_idle", 2, V_IDLE); run_q();

    // Burst of 3 pulses 2/1
    mode = MODE_BURST; high_len = 8'd2; low_len = 8'd1; burst_n = 4'd3; start = 1'b1;
    expect_n("burst", 1, V_HI); run_q(); start = 1'b0;
    expect_n("burst", 1, V_HI); expect_n("burst", 1, V_LO);
    for (int i = 0; i < 2; i++) begin
      expect_n("burst", 2, V_HI); expect_n("burst", 1, V_LO);
    end
    expect_n("burst_done", 1, V_DONE); expect_n("burst_idle", 1, V_IDLE); run_q();

    // Burst of zero pulses
    burst_n = 4'd0; start = 1'b1;
    expect_n("burst0_done", 1, V_DONE); run_q(); start = 1'b0;
    expect_n("burst0_idle", 2, V_IDLE); run_q();

    // Zero lengths in PWM behave as toggle
    mode = MODE_PWM; high_len = 8'd0; low_len = 8'd0; start = 1'b1;
    expect_n("zlen", 1, V_HI); run_q(); start = 1'b0;
    expect_n("zlen", 1, V_LO); expect_n("zlen", 1, V_HI);
    expect_n("zlen", 1, V_LO); expect_n("zlen", 1, V_HI); run_q();
    stop = 1'b1; expect_n("zlen_stop", 1, V_IDLE); run_q(); stop = 1'b0;

    // Enable pause mid-HIGH, PWM 4/1
    high_len = 8'd4; low_len = 8'd1; start = 1'b1;
    expect_n("pause", 1, V_HI); run_q(); start = 1'b0;
    expect_n("pause", 1, V_HI); run_q(); en = 1'b0;
    expect_n("pause_frz", 3, V_HI); run_q(); en = 1'b1;
    expect_n("pause_res", 2, V_HI); expect_n("pause_res", 1, V_LO);
    expect_n("pause_res", 4, V_HI); expect_n("pause_res", 1, V_LO); run_q();
    stop = 1'b1; expect_n("pause_stop", 1, V_IDLE); run_q(); stop = 1'b0;

    // Start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    expect_n("startstop", 1, V_IDLE); run_q(); start = 1'b0; stop = 1'b0;
    expect_n("startstop", 1, V_IDLE); run_q();

    // Asynchronous reset mid-burst, then a normal one-shot
    mode = MODE_BURST; high_len = 8'd2; low_len = 8'd2; burst_n = 4'd5; start = 1'b1;
    expect_n("rburst", 1, V_HI); run_q(); start = 1'b0;
    expect_n("rburst", 1, V_HI); expect_n("rburst", 2, V_LO);
    expect_n("rburst", 1, V_HI); run_q();
    #2 rst = 1'b0;
    #1 check("rst_async", {y, busy, done}, V_IDLE);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_hold", {y, busy, done}, V_IDLE);
    mode = MODE_ONESHOT; high_len = 8'd2; start = 1'b1;
    expect_n("post_rst", 1, V_HI); run_q(); start = 1'b0;
    expect_n("post_rst", 1, V_HI); expect_n("post_rst_done", 1, V_DONE);
    expect_n("post_rst_idle", 1, V_IDLE); run_q();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_wave_gen.md
Name: prog_wave_gen

Overview:
- Parametrised successor to the two-state toggle FSM.
- Generates a single registered waveform `y` with programmable high/low durations.
- Four modes: toggle, continuous PWM, one-shot pulse, counted burst.
- Sits beside control logic as a timing/strobe source.
- Adds start/stop/enable control and busy/done status, which the plain toggler lacks.

Parameters:
- CNT_W, 8, width of the high/low duration inputs and the internal down-counter.
- BURST_W, 4, width of the burst pulse-count input and the remaining-pulse counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- en  in  1  count enable; 0 freezes state, counters and y.
- start  in  1  single-cycle request; accepted only in IDLE.
- stop  in  1  synchronous abort; returns to IDLE from any state.
- mode  in  2  00 toggle, 01 continuous PWM, 10 one-shot, 11 burst.
- high_len  in  CNT_W  high-phase length in cycles (0 treated as 1).
- low_len  in  CNT_W  low-phase length in cycles (0 treated as 1).
- burst_n  in  BURST_W  number of pulses in burst mode.
- y  out  1  waveform, registered.
- busy  out  1  1 while state is not IDLE.
- done  out  1  one-cycle pulse on normal completion (one-shot/burst only).

Behaviour:
- Reset (rst=0, async): state=IDLE, y=0, busy=0, done=0, all counters and shadow registers 0. Reset mid-run aborts immediately with no done.
- States: IDLE, HIGH, LOW. Outputs are registered: y=1 iff state==HIGH; busy=1 iff state!=IDLE.
- Shadow config: on accepted start, latch mode, high_len, low_len, burst_n.
  - Toggle mode forces both shadow lengths to 1.
  - A length of 0 is latched as 1.
- IDLE + start (en=1, stop=0) -> HIGH next cycle, cnt=hl-1. y rises on the first edge after start is sampled (latency 1).
- HIGH, cnt!=0 -> cnt-1.
- HIGH, cnt==0:
  - one-shot -> IDLE, done=1 for one cycle.
  - otherwise -> LOW, cnt=ll-1.
- LOW, cnt!=0 -> cnt-1.
- LOW, cnt==0:
  - toggle/PWM -> HIGH, cnt=hl-1. Shadow lengths reload from the inputs here only, so period updates are glitch-free at period boundaries.
  - burst with remaining==1 -> IDLE, done=1.
  - burst otherwise -> HIGH, remaining-1.
- Burst with burst_n=0: start -> IDLE stays, done=1 next cycle, y stays 0.
- Timing consequences:
  - Waveform period = hl+ll cycles.
  - Toggle mode gives y = 1,0,1,0... starting the cycle after start.
- Control precedence: stop > en > start.
  - stop=1 -> IDLE next cycle, y=0, no done, regardless of en.
  - en=0 with stop=0 -> everything holds, done stays 0.
  - start in a non-IDLE state is ignored.
  - start and stop in the same cycle: stop wins, block stays IDLE.
- Counter arithmetic: unsigned, no wrap. The counter only decrements when nonzero.

Decomposition:
- Package prog_wave_gen_pkg:
  - state enum {IDLE, HIGH, LOW}.
  - mode constants MODE_TOGGLE=2'b00, MODE_PWM=2'b01, MODE_ONESHOT=2'b10, MODE_BURST=2'b11.
- One natural sub-module: wave_down_cnt, a loadable down-counter with load/dec/zero flag, parametrised by width.
  - Instantiated twice: phase counter (CNT_W) and burst counter (BURST_W).
- FSM, shadow registers and output registers stay in the top.

Test Plan:
- Toggle: mode=00, start at cycle 0, en=1 -> y=1,0,1,0,... from cycle 1; busy=1; done never asserted.
- PWM: mode=01, high_len=3, low_len=2 -> y=1,1,1,0,0 repeating (period 5). Change high_len to 1 mid-HIGH -> the new duty appears only after the current LOW phase ends.
- One-shot: mode=10, high_len=4 -> y high for 4 cycles, then y=0 with done=1 for exactly 1 cycle, busy drops with it. A second start while busy is ignored.
- Burst: mode=11, burst_n=3, high_len=2, low_len=1 -> y=1,1,0,1,1,0,1,1,0, then done pulse. burst_n=0 -> done=1 one cycle after start, y stays 0.
- Zero lengths plus en pause: high_len=0, low_len=0, mode=01 -> behaves as toggle. en=0 for 3 cycles mid-HIGH -> y and phase frozen, then resumes with the remaining count.
- Abort: assert stop mid-PWM -> y=0, busy=0 next cycle, no done. Drive rst=0 asynchronously mid-burst -> y, busy, done =0 immediately. After rst=1, start runs normally.
